// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//
// Result/flag stage sitting directly behind the 16-bit ALU.
//   - Accepts one ALU result per valid/ready handshake.
//   - Updates the architectural N/Z/C/V flag register under a per-bit mask.
//     A direct flag load overrides the masked update.
//   - Queues register-file writebacks in a small in-order FIFO.
//   - o_carry feeds the stored carry back to the ALU, so a chained
//     add/subtract sees the new carry on the very next cycle.
//
// Optional feature macro: ALU_RESULT_BYPASS_EN
//   When this macro is defined, a writeback that arrives while the FIFO is
//   empty and the register file is ready is presented combinationally in
//   the same cycle. The entry is never stored.
//
// Ports
//   i_clk, i_rst              clock (rising edge), synchronous active-high reset
//   i_valid / o_ready         ALU result handshake
//   i_data, i_flag            ALU o_data and o_flag (bit3 N, bit2 Z, bit1 C, bit0 V)
//   i_flag_we                 per-bit flag update mask, applied on accept
//   i_wb_en, i_dst            writeback enable and destination register index
//   i_flag_ld, i_flag_ld_data direct flag load (flag-restore instructions)
//   o_flag, o_carry           flag register and its carry bit
//   o_wb_valid / i_wb_ready   writeback handshake towards the register file
//   o_wb_data, o_wb_dst       head writeback entry
// ---------------------------------------------------------------------------
module alu_result_stage #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic [3:0]       i_flag,
    input  logic [3:0]       i_flag_we,
    input  logic             i_wb_en,
    input  logic [3:0]       i_dst,
    input  logic             i_flag_ld,
    input  logic [3:0]       i_flag_ld_data,
    output logic [3:0]       o_flag,
    output logic             o_carry,
    output logic             o_wb_valid,
    input  logic             i_wb_ready,
    output logic [WIDTH-1:0] o_wb_data,
    output logic [3:0]       o_wb_dst
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] CNT_ZERO = '0;
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_TWO  = (AW+1)'(2);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [3:0]       flag_reg;
    logic [3:0]       flag_next;
    logic [3:0]       flag_masked;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_inc;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [3:0]       dst_mem  [DEPTH];
    logic [WIDTH-1:0] head_data_reg;
    logic [3:0]       head_dst_reg;

    logic accept;
    logic push;
    logic pop;
    logic fifo_valid;
    logic bypass;

    assign o_ready    = (count_reg < CNT_FULL);
    assign accept     = i_valid && o_ready;
    assign fifo_valid = (count_reg != CNT_ZERO);
    assign pop        = fifo_valid && i_wb_ready;
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;

`ifdef ALU_RESULT_BYPASS_EN
    // Empty FIFO and a ready register file: hand the result straight through.
    assign bypass     = (count_reg == CNT_ZERO) && i_valid && i_wb_en && i_wb_ready;
    assign o_wb_valid = fifo_valid || bypass;
    assign o_wb_data  = bypass ? i_data : head_data_reg;
    assign o_wb_dst   = bypass ? i_dst  : head_dst_reg;
`else
    assign bypass     = 1'b0;
    assign o_wb_valid = fifo_valid;
    assign o_wb_data  = head_data_reg;
    assign o_wb_dst   = head_dst_reg;
`endif

    // A bypassed entry is consumed in place and never occupies a slot.
    assign push = accept && i_wb_en && !bypass;

    // Per-bit masked flag update.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_flag_mask
            assign flag_masked[gi] = i_flag_we[gi] ? i_flag[gi] : flag_reg[gi];
        end
    endgenerate

    always_comb begin
        flag_next = flag_reg;
        if (accept) begin
            flag_next = flag_masked;
        end
        // Direct load wins over a simultaneous accept on all four bits.
        if (i_flag_ld) begin
            flag_next = i_flag_ld_data;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // Entry storage: no reset needed, occupancy is tracked by count_reg.
    always_ff @(posedge i_clk) begin
        if (!i_rst && push) begin
            data_mem[wr_ptr_reg] <= i_data;
            dst_mem[wr_ptr_reg]  <= i_dst;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            flag_reg      <= 4'h0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= CNT_ZERO;
            head_data_reg <= '0;
            head_dst_reg  <= 4'h0;
        end else begin
            flag_reg  <= flag_next;
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            // The head register is a registered copy of the oldest entry.
            // It reloads only when the head changes, so it holds its value
            // while stalled or empty.
            if (pop && (count_reg >= CNT_TWO)) begin
                head_data_reg <= data_mem[rd_ptr_inc];
                head_dst_reg  <= dst_mem[rd_ptr_inc];
            end else if (push && ((count_reg == CNT_ZERO) ||
                                  (pop && (count_reg == CNT_ONE)))) begin
                head_data_reg <= i_data;
                head_dst_reg  <= i_dst;
            end
        end
    end

    assign o_flag  = flag_reg;
    assign o_carry = flag_reg[1];

endmodule

// File: tb/tb_alu_result_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_result_stage
//
// Directed self-checking bench for alu_result_stage (WIDTH=16, DEPTH=2).
// Inputs change 1 time unit after the rising edge. Outputs are sampled in
// the same window, away from the edge.
// ---------------------------------------------------------------------------
module tb_alu_result_stage;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        ready;
    logic [15:0] data;
    logic [3:0]  flag_in;
    logic [3:0]  flag_we;
    logic        wb_en;
    logic [3:0]  dst;
    logic        flag_ld;
    logic [3:0]  flag_ld_data;
    logic [3:0]  flag_out;
    logic        carry;
    logic        wb_valid;
    logic        wb_ready;
    logic [15:0] wb_data;
    logic [3:0]  wb_dst;

    int checks = 0;
    int failures = 0;

    alu_result_stage #(.WIDTH(16), .DEPTH(2)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_valid        (valid),
        .o_ready        (ready),
        .i_data         (data),
        .i_flag         (flag_in),
        .i_flag_we      (flag_we),
        .i_wb_en        (wb_en),
        .i_dst          (dst),
        .i_flag_ld      (flag_ld),
        .i_flag_ld_data (flag_ld_data),
        .o_flag         (flag_out),
        .o_carry        (carry),
        .o_wb_valid     (wb_valid),
        .i_wb_ready     (wb_ready),
        .o_wb_data      (wb_data),
        .o_wb_dst       (wb_dst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid        = 1'b0;
        data         = 16'h0;
        flag_in      = 4'h0;
        flag_we      = 4'h0;
        wb_en        = 1'b0;
        dst          = 4'h0;
        flag_ld      = 1'b0;
        flag_ld_data = 4'h0;
    endtask

    // Wrap-around vectors, emitted in this order.
    logic [15:0] wrap_data [7] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                                   16'h5555, 16'h6666, 16'h7777};
    logic [3:0]  wrap_dst  [7] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};

    initial begin
        int sent;
        int recv;
        idle();
        rst      = 1'b1;
        wb_ready = 1'b0;

        // ---------------- reset ----------------
        step();
        step();
        rst = 1'b0;
        check("rst_flag",     32'(flag_out), 32'h0);
        check("rst_carry",    32'(carry),    32'h0);
        check("rst_wb_valid", 32'(wb_valid), 32'h0);
        check("rst_ready",    32'(ready),    32'h1);
        check("rst_wb_data",  32'(wb_data),  32'h0);
        check("rst_wb_dst",   32'(wb_dst),   32'h0);

        // ---------------- single writeback ----------------
        valid = 1'b1; data = 16'h0003; flag_in = 4'b0000; flag_we = 4'hF;
        wb_en = 1'b1; dst = 4'h2; wb_ready = 1'b1;
        step();
        idle();
`ifdef ALU_RESULT_BYPASS_EN
        // Consumed by the bypass in the accept cycle; nothing left queued.
        check("t1_wb_valid_n1", 32'(wb_valid), 32'h0);
`else
        check("t1_wb_valid_n1", 32'(wb_valid), 32'h1);
        check("t1_wb_data",     32'(wb_data),  32'h0003);
        check("t1_wb_dst",      32'(wb_dst),   32'h2);
`endif
        step();
        check("t1_wb_valid_n2", 32'(wb_valid), 32'h0);

        // ---------------- flag mask ----------------
        flag_ld = 1'b1; flag_ld_data = 4'b1111;
        step();
        idle();
        check("fm_load", 32'(flag_out), 32'hF);
        valid = 1'b1; flag_in = 4'b0000; flag_we = 4'b0010; wb_en = 1'b0;
        step();
        idle();
        check("fm_flag",     32'(flag_out), 32'hD);
        check("fm_carry",    32'(carry),    32'h0);
        check("fm_no_push",  32'(wb_valid), 32'h0);

        // ---------------- backpressure ----------------
        wb_ready = 1'b0;
        valid = 1'b1; wb_en = 1'b1; data = 16'h0001; dst = 4'h1;
        step();
        data = 16'h0002; dst = 4'h3;
        step();
        check("bp_ready_full", 32'(ready),    32'h0);
        check("bp_head_data",  32'(wb_data),  32'h0001);
        data = 16'h0003; dst = 4'h5;
        step();
        check("bp_still_full", 32'(ready),    32'h0);
        check("bp_head_hold",  32'(wb_data),  32'h0001);
        check("bp_dst_hold",   32'(wb_dst),   32'h1);
        wb_ready = 1'b1;
        step();
        check("bp_pop2_data",  32'(wb_data),  32'h0002);
        check("bp_pop2_dst",   32'(wb_dst),   32'h3);
        check("bp_ready_open", 32'(ready),    32'h1);
        step();
        idle();
        check("bp_pop3_valid", 32'(wb_valid), 32'h1);
        check("bp_pop3_data",  32'(wb_data),  32'h0003);
        check("bp_pop3_dst",   32'(wb_dst),   32'h5);
        step();
        check("bp_drained",    32'(wb_valid), 32'h0);

        // ---------------- wrap-around ----------------
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 40 && recv < 7; cyc++) begin
            wb_ready = cyc[0];
            if (sent < 7) begin
                valid = 1'b1; wb_en = 1'b1; data = wrap_data[sent]; dst = wrap_dst[sent];
                flag_we = 4'h0;
            end else begin
                idle();
            end
            #1;
            if (wb_valid && wb_ready) begin
                check($sformatf("wrap_data_%0d", recv), 32'(wb_data), 32'(wrap_data[recv]));
                check($sformatf("wrap_dst_%0d", recv),  32'(wb_dst),  32'(wrap_dst[recv]));
                recv++;
            end
            if (valid && ready) sent++;
            step();
        end
        idle();
        check("wrap_count", 32'(recv), 32'd7);
        wb_ready = 1'b0;

        // ---------------- flag load vs accept ----------------
        valid = 1'b1; flag_in = 4'b0101; flag_we = 4'hF; wb_en = 1'b0;
        flag_ld = 1'b1; flag_ld_data = 4'b1010;
        step();
        idle();
        check("ld_override_flag",  32'(flag_out), 32'hA);
        check("ld_override_carry", 32'(carry),    32'h1);

        // ---------------- reset with entries queued ----------------
        valid = 1'b1; wb_en = 1'b1; data = 16'h0055; dst = 4'h8;
        step();
        data = 16'h0066; dst = 4'h9;
        step();
        idle();
        check("rq_queued", 32'(wb_valid), 32'h1);
        rst = 1'b1;
        flag_ld = 1'b1; flag_ld_data = 4'hF;
        valid = 1'b1; wb_en = 1'b1; data = 16'h0077;
        step();
        rst = 1'b0;
        idle();
        wb_ready = 1'b1;
        check("rq_wb_valid", 32'(wb_valid), 32'h0);
        check("rq_flag",     32'(flag_out), 32'h0);
        check("rq_ready",    32'(ready),    32'h1);
        check("rq_wb_data",  32'(wb_data),  32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("rq_no_out_%0d", k), 32'(wb_valid), 32'h0);
        end

        // ---------------- bypass / same-cycle ----------------
        valid = 1'b1; wb_en = 1'b1; data = 16'h00AA; dst = 4'h7; wb_ready = 1'b1;
        #1;
`ifdef ALU_RESULT_BYPASS_EN
        check("byp_same_valid", 32'(wb_valid), 32'h1);
        check("byp_same_data",  32'(wb_data),  32'h00AA);
        check("byp_same_dst",   32'(wb_dst),   32'h7);
        step();
        idle();
        check("byp_count_zero", 32'(wb_valid), 32'h0);
`else
        check("byp_same_valid", 32'(wb_valid), 32'h0);
        step();
        idle();
        check("byp_next_valid", 32'(wb_valid), 32'h1);
        check("byp_next_data",  32'(wb_data),  32'h00AA);
        step();
        check("byp_drained",    32'(wb_valid), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
